booth_divider_seq: RTL

- Iterative signed divider. It is the inverse operation to the team's combinational Booth multiplier: it takes the product-side operands and returns quotient and remainder.
- Radix-2 non-restoring algorithm on operand magnitudes, followed by remainder correction and sign fix-up.
- start/done handshake, one iteration per clock.
- Used in the COA arithmetic suite alongside the multiplier blocks.

---
 rtl/booth_divider_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/booth_divider_seq.sv
// Iterative signed divider: radix-2 non-restoring division on operand magnitudes,
// then remainder correction and sign fix-up. Optional flags under BOOTH_DIV_FLAGS_EN.
module booth_divider_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] M,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef BOOTH_DIV_FLAGS_EN
  ,
  output logic         dbz,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N:0]    a_q;
  logic [N-1:0]  qr_q;
  logic [N-1:0]  m_abs_q;
  logic          sq_q;
  logic          sm_q;
  logic          dbz_pend_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
`ifdef BOOTH_DIV_FLAGS_EN
  logic          ovf_pend_q;
  logic          dbz_q;
  logic          ovf_q;
`endif

  logic [N:0]   m_ext;
  logic [N:0]   a_sh;
  logic [N:0]   a_step_d;
  logic [N-1:0] qr_step_d;
  logic [N:0]   a_fix;
  logic [N-1:0] q_abs_d;
  logic [N-1:0] m_abs_d;
  logic [N-1:0] quot_d;
  logic [N-1:0] rem_d;
  logic         ovf_in;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    m_ext     = {1'b0, m_abs_q};
    a_sh      = {a_q[N-1:0], qr_q[N-1]};
    a_step_d  = a_q[N] ? (a_sh + m_ext) : (a_sh - m_ext);
    qr_step_d = {qr_q[N-2:0], ~a_step_d[N]};
    a_fix     = a_q[N] ? (a_q + m_ext) : a_q;
    q_abs_d   = Q[N-1] ? (~Q + 1'b1) : Q;
    m_abs_d   = M[N-1] ? (~M + 1'b1) : M;
    ovf_in    = (Q == {1'b1, {(N-1){1'b0}}}) && (M == {N{1'b1}});
    quot_d    = (sq_q ^ sm_q) ? (~qr_q + 1'b1) : qr_q;
    rem_d     = sq_q ? (~a_fix[N-1:0] + 1'b1) : a_fix[N-1:0];
    // Divide by zero: qr_q still holds |Q|, so the dividend is rebuilt from it.
    if (dbz_pend_q) begin
      quot_d = {N{1'b1}};
      rem_d  = sq_q ? (~qr_q + 1'b1) : qr_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      qr_q       <= '0;
      m_abs_q    <= '0;
      sq_q       <= 1'b0;
      sm_q       <= 1'b0;
      dbz_pend_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
`ifdef BOOTH_DIV_FLAGS_EN
      ovf_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sq_q       <= Q[N-1];
            sm_q       <= M[N-1];
            qr_q       <= q_abs_d;
            m_abs_q    <= m_abs_d;
            a_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            dbz_pend_q <= (M == '0);
`ifdef BOOTH_DIV_FLAGS_EN
            ovf_pend_q <= ovf_in;
`endif
            state_q    <= (M == '0) ? S_FIX : S_ITER;
          end
        end
        S_ITER: begin
          a_q   <= a_step_d;
          qr_q  <= qr_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quot_q  <= quot_d;
          rem_q   <= rem_d;
`ifdef BOOTH_DIV_FLAGS_EN
          dbz_q   <= dbz_pend_q;
          ovf_q   <= ovf_pend_q;
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef BOOTH_DIV_FLAGS_EN
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
`endif

  // ovf_in is only consumed when the flags are built in.
  logic unused_ok;
  assign unused_ok = ovf_in;

endmodule
